// File: rtl/hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler
//
// Time-shares a single hex-to-seven-segment decoder across NUM_DIGITS HEX
// digits. A packed value is accepted over a valid/ready handshake. It is
// scanned one digit per cycle, most significant first, into a staging
// buffer. The staging buffer is then committed to the display registers in
// a single edge, so the pins never show a half-updated number. Optional
// leading-zero blanking and a free-running whole-display blink are applied.
//
// Parameters
//   NUM_DIGITS  number of HEX digits driven (1..8)
//   BLINK_DIV   clock cycles per blink half-period (>= 2)
//
// Ports
//   clock     in   system clock, all state on the rising edge
//   resetn    in   asynchronous active-low reset
//   value     in   packed hex value, nibble i = digit i (digit 0 = LSD)
//   blank_lz  in   blank leading zeros, sampled together with value
//   load      in   request valid
//   ready     out  high when a load will be accepted (FSM idle)
//   done      out  one-cycle pulse when new patterns reach hex_flat
//   blink_en  in   live blink enable (masks the display while phase is high)
//   hex_flat  out  active-low segments, digit i at [7i+6:7i], order g..a
// ---------------------------------------------------------------------------

// Single shared decoder: 4-bit hex in, active-low segments g..a out.
module hex_seg_decoder (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      seg = 7'b1111111;
      unique case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'ha: seg = 7'b0001000;
         4'hb: seg = 7'b0000011;
         4'hc: seg = 7'b1000110;
         4'hd: seg = 7'b0100001;
         4'he: seg = 7'b0000110;
         4'hf: seg = 7'b0001110;
      endcase
   end

endmodule

module hex_display_scheduler #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    blank_lz,
   input  logic                    load,
   output logic                    ready,
   output logic                    done,
   input  logic                    blink_en,
   output logic [7*NUM_DIGITS-1:0] hex_flat
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [6:0] BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [4*NUM_DIGITS-1:0] sh_value;
   logic                    sh_blank_lz;
   logic [IDX_W-1:0]        idx;
   logic                    lz;
   logic [6:0]              staged  [NUM_DIGITS];
   logic [6:0]              display [NUM_DIGITS];
   logic [CNT_W-1:0]        blink_cnt;
   logic                    phase;

   logic [3:0]              nibble;
   logic [6:0]              seg;
   logic                    blank_digit;

   assign ready = (state == IDLE);

   // Decoder input is the shadow nibble currently addressed by the scan.
   assign nibble = sh_value[4*idx +: 4];

   hex_seg_decoder u_decoder (
      .nibble (nibble),
      .seg    (seg)
   );

   // Still inside the run of leading zeros; digit 0 always shows.
   assign blank_digit = sh_blank_lz && lz && (nibble == 4'd0) && (idx != '0);

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (load)      next_state = SCAN;
         SCAN:    if (idx == '0) next_state = COMMIT;
         COMMIT:                 next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: capture, scan into staging, atomic commit
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sh_value    <= '0;
         sh_blank_lz <= 1'b0;
         idx         <= '0;
         lz          <= 1'b0;
         done        <= 1'b0;
         // NOTE: the segment buffers are reset on purpose: reset must blank
         // the pins at once and discard any pending update, so these are
         // flops with reset, not a RAM.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            staged[i]  <= BLANK;
            display[i] <= BLANK;
         end
      end else begin
         done <= (state == COMMIT);
         unique case (state)
            IDLE: begin
               if (load) begin
                  sh_value    <= value;
                  sh_blank_lz <= blank_lz;
                  idx         <= IDX_W'(NUM_DIGITS - 1);
                  lz          <= 1'b1;
               end
            end
            SCAN: begin
               staged[idx] <= blank_digit ? BLANK : seg;
               if (!blank_digit) lz <= 1'b0;
               if (idx != '0) idx <= idx - 1'b1;
            end
            COMMIT: begin
               for (int i = 0; i < NUM_DIGITS; i++) display[i] <= staged[i];
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Free-running blink timebase; blink_en only masks, never restarts it.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
      assign hex_flat[7*g +: 7] = (blink_en && phase) ? BLANK : display[g];
   end

endmodule
